ahb_arbiter_gen: RTL and testbench
==================================

Name: ahb_arbiter_gen

Overview:
Parametrised, burst-aware AHB slave-side arbiter. It supersedes the per-slave generated arbiters, which fixed the arbitration scheme at generation time.
- Master count and priority depth are parameters.
- The arbitration scheme (fixed, round-robin or dynamic priority) is chosen by parameter.
- Adds an undefined-length INCR hold limit and zero-bubble back-to-back handover.
- Sits between the master request lines and one slave port of the AHB interconnect. Drives the one-hot grant, the owner index and the last-beat strobe.

Parameters:
- MASTER_NUM, 4: number of requesting masters (2..16).
- PRIOR_LEVEL, 4: number of dynamic priority levels (mode 2 only).
- PRIOR_BIT, $clog2(PRIOR_LEVEL): width of each priority field.
- ARB_MODE, 1: 0 = fixed (lowest index wins), 1 = round-robin, 2 = dynamic priority.
- MAX_HOLD, 16: maximum accepted beats for an INCR (undefined-length) burst before forced release (1..256).
- IDX_W, $clog2(MASTER_NUM): width of hmaster.

Ports:
- hclk, in, 1: clock; all logic on rising edge.
- hreset, in, 1: synchronous, active-high reset.
- hreq, in, MASTER_NUM: per-master bus request.
- hprior, in, MASTER_NUM*PRIOR_BIT: per-master priority, larger = higher; ignored unless ARB_MODE = 2.
- hburst, in, 3: burst type of the current owner. AHB encoding: 0 SINGLE, 1 INCR, 2 WRAP4, 3 INCR4, 4 WRAP8, 5 INCR8, 6 WRAP16, 7 INCR16.
- hwait, in, 1: slave wait; a beat is accepted in a cycle where the grant is nonzero and hwait = 0.
- hgrant, out, MASTER_NUM: registered one-hot grant; all zero when idle.
- hmaster, out, IDX_W: binary index of the granted master; 0 when idle.
- hsel, out, 1: high when any grant is active (|hgrant).
- hlast, out, 1: combinational strobe, high on the accepted last beat of the owner's burst.

Behaviour:
- Reset (hreset = 1 at an edge): hgrant = 0, hmaster = 0, beat count = 0, latched burst = SINGLE, state = IDLE, round-robin pointer = 0. Takes effect mid-burst with no completion; the burst is abandoned.
- States: IDLE (no owner) and OWN (one master holds the grant).
- IDLE: if any hreq, the winner is registered into hgrant at the next edge and state goes to OWN; otherwise stay IDLE. Latency from request to grant is 1 cycle.
- Winner selection:
  - Mode 0: lowest set index of hreq.
  - Mode 1: first requester at or above the pointer, scanning cyclically upward.
  - Mode 2: highest hprior among requesters; ties go to the lowest index.
- OWN, beat count: the count increments per accepted beat and is held while hwait = 1.
- OWN, burst type: on the first accepted beat (count = 0), hburst is latched. The burst length is 1, 4, 8 or 16 for SINGLE, x4, x8, x16. For the count = 0 beat the live hburst is used.
- OWN, last beat:
  - Fixed-length burst: accepted beat with count = length-1.
  - INCR: accepted beat with either hreq[owner] = 0 or count = MAX_HOLD-1.
  - hlast is asserted on that beat.
- Owner deasserting hreq during a fixed-length burst is ignored; the burst runs to completion.
- On the last beat:
  - Mode 1: the pointer is set to (owner+1) mod MASTER_NUM.
  - If any hreq is set (including the current owner): the new winner loads hgrant at the same edge, count is cleared, and state stays OWN. There is no idle cycle between owners.
  - Otherwise: hgrant clears and state goes to IDLE.
- hgrant never changes in OWN except on a last beat.
- hprior changes are sampled only at arbitration points.
- Simultaneous last beat and a new request from the same owner: in mode 1 the owner is lowest priority and wins only if it is the sole requester. In modes 0 and 2 it re-wins per normal rules.
- Count is 8 bits wide and never wraps within a burst.

Test Plan:
- Reset/idle: hreset = 1 for 2 cycles, hreq = 4'b1010 → hgrant = 0, hsel = 0, hmaster = 0. Release reset → hgrant = 4'b0010 one cycle later.
- Round-robin, ARB_MODE = 1: hreq = 4'b1111, all SINGLE, hwait = 0 → grants cycle 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with hlast = 1 every cycle.
- INCR8 with waits: owner m2, hwait high on beats 3 and 5 → hgrant stays 0100 for 10 cycles. hlast is high only on the 8th accepted beat; a new requester m0 is granted the next cycle.
- INCR hold limit: MAX_HOLD = 16, m1 holds hreq with hburst = INCR, m3 requesting → hlast on the 16th accepted beat, then hgrant = 1000. If m1 drops hreq after 5 beats instead, hlast occurs on beat 5.
- Dynamic priority, ARB_MODE = 2: hprior = {m3:1, m2:3, m1:3, m0:0}, all requesting → m1 wins. After its SINGLE, set m2 = 0 → m1 wins again.
- Mid-burst reset: reset asserted on beat 2 of a WRAP4 → next cycle hgrant = 0 and hlast = 0. The first grant after reset follows pointer = 0.

Source files
------------

// File: rtl/ahb_arbiter_gen.sv
// Burst-aware AHB slave-side arbiter: fixed, round-robin or dynamic-priority winner
// selection, registered one-hot grant and zero-bubble handover on the last beat.
module ahb_arbiter_gen #(
    parameter int MASTER_NUM  = 4,
    parameter int PRIOR_LEVEL = 4,
    parameter int PRIOR_BIT   = $clog2(PRIOR_LEVEL),
    parameter int ARB_MODE    = 1,
    parameter int MAX_HOLD    = 16,
    parameter int IDX_W       = $clog2(MASTER_NUM)
) (
    input  logic                            hclk,
    input  logic                            hreset,
    input  logic [MASTER_NUM-1:0]           hreq,
    input  logic [MASTER_NUM*PRIOR_BIT-1:0] hprior,
    input  logic [2:0]                      hburst,
    input  logic                            hwait,
    output logic [MASTER_NUM-1:0]           hgrant,
    output logic [IDX_W-1:0]                hmaster,
    output logic                            hsel,
    output logic                            hlast
);

    // state | meaning
    // IDLE  | no owner, grant all zero
    // OWN   | one master holds the grant until its last accepted beat
    typedef enum logic {IDLE, OWN} state_t;

    state_t                state_q, state_d;
    logic [MASTER_NUM-1:0] grant_d;
    logic [IDX_W-1:0]      master_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d, next_ptr, arb_ptr, win_idx;
    logic                  win_any;
    logic [PRIOR_BIT-1:0]  best_prio;
    logic [7:0]            cnt_q, cnt_d, burst_len;
    logic [2:0]            burst_q, burst_d, cur_burst;
    logic                  accept, owner_req, last_beat;

    assign hsel      = |hgrant;
    assign accept    = hsel & ~hwait;
    assign owner_req = hreq[hmaster];
    assign next_ptr  = (hmaster == IDX_W'(MASTER_NUM-1)) ? '0 : hmaster + IDX_W'(1);
    // At a handover the outgoing owner is scanned last, so it re-wins only when alone.
    assign arb_ptr   = (state_q == OWN) ? next_ptr : rr_ptr_q;
    assign cur_burst = (cnt_q == 8'd0) ? hburst : burst_q;

    always_comb begin
        int j;
        win_any   = 1'b0;
        win_idx   = '0;
        best_prio = '0;
        j         = 0;
        case (ARB_MODE)
            0: begin
                for (int i = MASTER_NUM-1; i >= 0; i--) begin
                    if (hreq[i]) begin
                        win_any = 1'b1;
                        win_idx = IDX_W'(i);
                    end
                end
            end
            1: begin
                for (int k = MASTER_NUM-1; k >= 0; k--) begin
                    j = int'(arb_ptr) + k;
                    if (j >= MASTER_NUM) j = j - MASTER_NUM;
                    if (hreq[j]) begin
                        win_any = 1'b1;
                        win_idx = IDX_W'(j);
                    end
                end
            end
            default: begin
                for (int i = 0; i < MASTER_NUM; i++) begin
                    if (hreq[i] && (!win_any || hprior[i*PRIOR_BIT +: PRIOR_BIT] > best_prio)) begin
                        win_any   = 1'b1;
                        win_idx   = IDX_W'(i);
                        best_prio = hprior[i*PRIOR_BIT +: PRIOR_BIT];
                    end
                end
            end
        endcase
    end

    always_comb begin
        case (cur_burst)
            3'd0:       burst_len = 8'd1;
            3'd2, 3'd3: burst_len = 8'd4;
            3'd4, 3'd5: burst_len = 8'd8;
            default:    burst_len = 8'd16;
        endcase
        if (cur_burst == 3'd1)
            last_beat = ~owner_req | (cnt_q == 8'(MAX_HOLD-1));
        else
            last_beat = (cnt_q == burst_len - 8'd1);
        hlast = (state_q == OWN) & accept & last_beat;
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = hgrant;
        master_d = hmaster;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        burst_d  = burst_q;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    state_d  = OWN;
                    grant_d  = MASTER_NUM'(1) << win_idx;
                    master_d = win_idx;
                    cnt_d    = 8'd0;
                end
            end
            OWN: begin
                if (accept) begin
                    if (cnt_q == 8'd0) burst_d = hburst;
                    if (hlast) begin
                        if (ARB_MODE == 1) rr_ptr_d = next_ptr;
                        cnt_d = 8'd0;
                        if (win_any) begin
                            grant_d  = MASTER_NUM'(1) << win_idx;
                            master_d = win_idx;
                        end else begin
                            state_d  = IDLE;
                            grant_d  = '0;
                            master_d = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q  <= IDLE;
            hgrant   <= '0;
            hmaster  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= 8'd0;
            burst_q  <= 3'd0;
        end else begin
            state_q  <= state_d;
            hgrant   <= grant_d;
            hmaster  <= master_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            burst_q  <= burst_d;
        end
    end

endmodule

// File: tb/tb_ahb_arbiter_gen.sv
// Directed bench for ahb_arbiter_gen: round-robin, fixed and dynamic-priority
// instances share stimulus; each step compares against hand-computed values.
module tb_ahb_arbiter_gen;

    logic       hclk = 1'b0;
    logic       hreset = 1'b1;
    logic [3:0] hreq = '0;
    logic [7:0] hprior = '0;
    logic [2:0] hburst = '0;
    logic       hwait = 1'b0;

    logic [3:0] rr_grant, fx_grant, dp_grant;
    logic [1:0] rr_master, fx_master, dp_master;
    logic       rr_sel, fx_sel, dp_sel;
    logic       rr_last, fx_last, dp_last;

    int n_total = 0;
    int n_fail  = 0;

    always #5 hclk = ~hclk;

    ahb_arbiter_gen #(.ARB_MODE(1)) u_rr (
        .hclk(hclk), .hreset(hreset), .hreq(hreq), .hprior(hprior), .hburst(hburst),
        .hwait(hwait), .hgrant(rr_grant), .hmaster(rr_master), .hsel(rr_sel), .hlast(rr_last));

    ahb_arbiter_gen #(.ARB_MODE(0)) u_fx (
        .hclk(hclk), .hreset(hreset), .hreq(hreq), .hprior(hprior), .hburst(hburst),
        .hwait(hwait), .hgrant(fx_grant), .hmaster(fx_master), .hsel(fx_sel), .hlast(fx_last));

    ahb_arbiter_gen #(.ARB_MODE(2)) u_dp (
        .hclk(hclk), .hreset(hreset), .hreq(hreq), .hprior(hprior), .hburst(hburst),
        .hwait(hwait), .hgrant(dp_grant), .hmaster(dp_master), .hsel(dp_sel), .hlast(dp_last));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic do_reset();
        hreset = 1'b1;
        hreq   = '0;
        hwait  = 1'b0;
        hburst = 3'd0;
        tick();
        hreset = 1'b0;
    endtask

    logic [3:0] rr_exp [5];

    initial begin
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // reset held with requests pending
        hreset = 1'b1;
        hreq   = 4'b1010;
        tick();
        tick();
        check("reset_grant", 32'(rr_grant), 32'h0);
        check("reset_sel", 32'(rr_sel), 32'h0);
        check("reset_master", 32'(rr_master), 32'h0);
        hreset = 1'b0;
        tick();
        check("first_grant", 32'(rr_grant), 32'b0010);
        check("first_master", 32'(rr_master), 32'd1);

        // round-robin over SINGLE transfers, fixed instance keeps m0
        do_reset();
        hreq = 4'b1111;
        #1;
        check("idle_hlast", 32'(rr_last), 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr_grant", 32'(rr_grant), 32'(rr_exp[i]));
            check("rr_hlast", 32'(rr_last), 32'h1);
            check("fx_grant", 32'(fx_grant), 32'b0001);
        end

        // INCR8 on m2 with two wait cycles; m2 drops hreq mid-burst, m0 arrives
        do_reset();
        hreq   = 4'b0100;
        hburst = 3'd5;
        tick();
        check("incr8_grant", 32'(rr_grant), 32'b0100);
        for (int i = 0; i < 10; i++) begin
            hwait = (i == 2 || i == 5);
            if (i == 3) hreq = 4'b0001;
            #1;
            check("incr8_hold", 32'(rr_grant), 32'b0100);
            check("incr8_hlast", 32'(rr_last), 32'(i == 9));
            tick();
        end
        hwait = 1'b0;
        check("incr8_handover", 32'(rr_grant), 32'b0001);
        check("incr8_master", 32'(rr_master), 32'd0);

        // INCR held to the MAX_HOLD limit
        do_reset();
        hreq   = 4'b1010;
        hburst = 3'd1;
        tick();
        check("hold_grant", 32'(rr_grant), 32'b0010);
        for (int i = 0; i < 16; i++) begin
            #1;
            check("hold_owner", 32'(rr_grant), 32'b0010);
            check("hold_hlast", 32'(rr_last), 32'(i == 15));
            tick();
        end
        check("hold_handover", 32'(rr_grant), 32'b1000);
        check("hold_master", 32'(rr_master), 32'd3);

        // INCR ended early by the owner dropping its request on beat 5
        do_reset();
        hreq   = 4'b1010;
        hburst = 3'd1;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) hreq = 4'b1000;
            #1;
            check("drop_hlast", 32'(rr_last), 32'(i == 4));
            tick();
        end
        check("drop_handover", 32'(rr_grant), 32'b1000);

        // dynamic priority: tie between m1/m2 goes to m1
        do_reset();
        hprior = 8'b01_11_11_00;
        hreq   = 4'b1111;
        tick();
        check("dp_tie", 32'(dp_grant), 32'b0010);
        hprior = 8'b01_00_11_00;
        #1;
        check("dp_hlast", 32'(dp_last), 32'h1);
        tick();
        check("dp_rewin", 32'(dp_grant), 32'b0010);
        check("dp_master", 32'(dp_master), 32'd1);
        hprior = 8'b01_00_00_00;
        tick();
        check("dp_m3", 32'(dp_grant), 32'b1000);

        // sole requester re-wins in round-robin, then reset lands mid WRAP4
        do_reset();
        hreq = 4'b0100;
        tick();
        check("sole_grant", 32'(rr_grant), 32'b0100);
        tick();
        check("sole_rewin", 32'(rr_grant), 32'b0100);
        hburst = 3'd2;
        tick();
        hreset = 1'b1;
        #1;
        check("wrap4_beat2_hlast", 32'(rr_last), 32'h0);
        check("wrap4_beat2_grant", 32'(rr_grant), 32'b0100);
        tick();
        check("midrst_grant", 32'(rr_grant), 32'h0);
        check("midrst_sel", 32'(rr_sel), 32'h0);
        check("midrst_hlast", 32'(rr_last), 32'h0);
        hreset = 1'b0;
        hreq   = 4'b1111;
        hburst = 3'd0;
        tick();
        check("midrst_ptr0", 32'(rr_grant), 32'b0001);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
